// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC measurement sequencer.
// State encoding, record layout helpers and default widths.
package tdc_pkg;

  localparam int NUM_DECODE_DEF  = 7;
  localparam int COUNTER_DIG_DEF = 10;

  // flag positions inside the 2-bit flag field at the top of a record
  localparam int FLAG_TO = 1;
  localparam int FLAG_ZW = 0;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUNNING,
    SETTLE,
    OUT
  } tdc_state_e;

  function automatic int rec_w(input int nd, input int cd);
    return 2 + cd + 2 * nd;
  endfunction

endpackage

// File: rtl/tdc_rec_reg.sv
// Valid/ready holding register for one measurement record.
// Load sets valid; a handshake clears it; data holds until reloaded.
module tdc_rec_reg #(
  parameter int W = 26
) (
  input  logic         iClk,
  input  logic         rst,
  input  logic         iLoad,
  input  logic [W-1:0] iData,
  input  logic         iReady,
  output logic         oValid,
  output logic [W-1:0] oData,
  output logic         oFire
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // next valid/data: handshake clears valid, load captures a new record
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && iReady) begin
      valid_d = 1'b0;
    end
    if (iLoad) begin
      valid_d = 1'b1;
      data_d  = iData;
    end
  end

  // record storage with synchronous reset
  always_ff @(posedge iClk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign oValid = valid_q;
  assign oData  = data_q;
  assign oFire  = valid_q & iReady;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the carry-chain TDC.
// Arms capture, tracks one hit, waits for decoders, emits one record.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter  int NUM_DECODE  = NUM_DECODE_DEF,
  parameter  int COUNTER_DIG = COUNTER_DIG_DEF,
  parameter  int SETTLE_CYC  = 2,
  parameter  int TIMEOUT_CYC = 1000,
  localparam int REC_W       = rec_w(NUM_DECODE, COUNTER_DIG)
) (
  input  logic                   iClk,
  input  logic                   rst,
  input  logic                   iArm,
  input  logic                   iRise,
  input  logic                   iFall,
  input  logic [COUNTER_DIG-1:0] iCoarse,
  input  logic [NUM_DECODE-1:0]  iDecStart,
  input  logic [NUM_DECODE-1:0]  iDecStop,
  output logic                   oFineClr,
  output logic                   oCoarseClr,
  output logic                   oCoarseEn,
  output logic                   oRecValid,
  input  logic                   iRecReady,
  output logic [REC_W-1:0]       oRecord,
  output logic                   oBusy,
  output logic [7:0]             oDropCnt
);

  tdc_state_e  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  settle_q, settle_d;
  logic [7:0]  drop_q, drop_d;
  logic        to_q, to_d;
  logic        zw_q, zw_d;
  logic        clr_q, clr_d;
  logic        cen_q, cen_d;
  logic        busy_q, busy_d;
  logic        load;
  logic        enter_arm;
  logic        rec_fire;
  logic [REC_W-1:0] rec_data;

  // record image as it will be latched at the end of SETTLE
  always_comb begin
    rec_data = {2'b00, iCoarse, iDecStart, iDecStop};
    rec_data[REC_W-2+FLAG_TO] = to_q;
    rec_data[REC_W-2+FLAG_ZW] = zw_q;
  end

  // sequencer next-state, timers, flags and drop counter
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    settle_d  = settle_q;
    to_d      = to_q;
    zw_d      = zw_q;
    drop_d    = drop_q;
    load      = 1'b0;
    enter_arm = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iArm) begin
          state_d   = ARMED;
          enter_arm = 1'b1;
        end
      end
      ARMED: begin
        if (!iArm) begin
          state_d = IDLE;
        end else if (iRise && iFall) begin
          state_d  = SETTLE;
          zw_d     = 1'b1;
          settle_d = '0;
        end else if (iRise) begin
          state_d = RUNNING;
          timer_d = '0;
        end
      end
      RUNNING: begin
        if (iFall) begin
          state_d  = SETTLE;
          settle_d = '0;
        end else if (timer_q == 16'(TIMEOUT_CYC - 1)) begin
          state_d  = SETTLE;
          to_d     = 1'b1;
          settle_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      SETTLE: begin
        if (settle_q == 8'(SETTLE_CYC - 1)) begin
          state_d = OUT;
          load    = 1'b1;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      OUT: begin
        if (rec_fire) begin
          if (iArm) begin
            state_d   = ARMED;
            enter_arm = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_arm) begin
      to_d = 1'b0;
      zw_d = 1'b0;
    end
    if (iRise && (state_q == SETTLE || state_q == OUT)
        && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // registered control outputs follow the next state
  always_comb begin
    clr_d  = enter_arm;
    cen_d  = (state_d == RUNNING);
    busy_d = (state_d != IDLE);
  end

  // state and counter registers, synchronous reset
  always_ff @(posedge iClk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      settle_q <= '0;
      drop_q   <= '0;
      to_q     <= 1'b0;
      zw_q     <= 1'b0;
      clr_q    <= 1'b0;
      cen_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      settle_q <= settle_d;
      drop_q   <= drop_d;
      to_q     <= to_d;
      zw_q     <= zw_d;
      clr_q    <= clr_d;
      cen_q    <= cen_d;
      busy_q   <= busy_d;
    end
  end

  tdc_rec_reg #(
    .W (REC_W)
  ) u_rec (
    .iClk   (iClk),
    .rst    (rst),
    .iLoad  (load),
    .iData  (rec_data),
    .iReady (iRecReady),
    .oValid (oRecValid),
    .oData  (oRecord),
    .oFire  (rec_fire)
  );

  assign oFineClr   = clr_q;
  assign oCoarseClr = clr_q;
  assign oCoarseEn  = cen_q;
  assign oBusy      = busy_q;
  assign oDropCnt   = drop_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl.
// Hand-computed records, latency, back-pressure and reset checks.
module tb_tdc_meas_ctrl;

  logic        iClk = 1'b0;
  logic        rst;
  logic        iArm, iRise, iFall;
  logic [9:0]  iCoarse;
  logic [6:0]  iDecStart, iDecStop;
  logic        oFineClr, oCoarseClr, oCoarseEn, oRecValid;
  logic        iRecReady;
  logic [25:0] oRecord;
  logic        oBusy;
  logic [7:0]  oDropCnt;

  int n_chk  = 0;
  int n_pass = 0;
  int clr_cnt = 0;
  int hs_cnt  = 0;

  always #5 iClk = ~iClk;

  tdc_meas_ctrl dut (
    .iClk       (iClk),
    .rst        (rst),
    .iArm       (iArm),
    .iRise      (iRise),
    .iFall      (iFall),
    .iCoarse    (iCoarse),
    .iDecStart  (iDecStart),
    .iDecStop   (iDecStop),
    .oFineClr   (oFineClr),
    .oCoarseClr (oCoarseClr),
    .oCoarseEn  (oCoarseEn),
    .oRecValid  (oRecValid),
    .iRecReady  (iRecReady),
    .oRecord    (oRecord),
    .oBusy      (oBusy),
    .oDropCnt   (oDropCnt)
  );

  always @(posedge iClk) begin
    if (oFineClr) clr_cnt++;
    if (oRecValid && iRecReady) hs_cnt++;
  end

  function automatic logic [31:0] rec(
    input logic to, input logic zw, input int c,
    input int s, input int p);
    return {6'd0, to, zw, 10'(c), 7'(s), 7'(p)};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max && !oRecValid; i++) tick();
    chk(tag, 32'(oRecValid), 32'd1);
  endtask

  task automatic hit(input int gap, input int c,
                     input int s, input int p);
    iRise = 1'b1;
    tick();
    iRise = 1'b0;
    ticks(gap);
    iFall = 1'b1;
    iCoarse = 10'(c);
    iDecStart = 7'(s);
    iDecStop = 7'(p);
    tick();
    iFall = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    int base, hbase;
    bit bad;
    rst = 1'b1;
    iArm = 1'b0;
    iRise = 1'b0;
    iFall = 1'b0;
    iCoarse = '0;
    iDecStart = '0;
    iDecStop = '0;
    iRecReady = 1'b0;
    ticks(2);
    chk("rst_valid", 32'(oRecValid), 0);
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_cen", 32'(oCoarseEn), 0);
    chk("rst_clr", 32'(oFineClr), 0);
    chk("rst_rec", 32'(oRecord), 0);
    chk("rst_drop", 32'(oDropCnt), 0);
    rst = 1'b0;

    // 1: normal hit, latency
    iArm = 1'b1;
    iRecReady = 1'b1;
    tick();
    chk("t1_fineclr", 32'(oFineClr), 1);
    chk("t1_coarseclr", 32'(oCoarseClr), 1);
    chk("t1_busy", 32'(oBusy), 1);
    iRise = 1'b1;
    tick();
    iRise = 1'b0;
    chk("t1_cen", 32'(oCoarseEn), 1);
    chk("t1_clr_once", 32'(oFineClr), 0);
    ticks(36);
    iFall = 1'b1;
    iCoarse = 10'd37;
    iDecStart = 7'd5;
    iDecStop = 7'd90;
    tick();
    iFall = 1'b0;
    chk("t1_lat1", 32'(oRecValid), 0);
    chk("t1_cen_off", 32'(oCoarseEn), 0);
    tick();
    chk("t1_lat2", 32'(oRecValid), 0);
    tick();
    chk("t1_lat3", 32'(oRecValid), 1);
    chk("t1_rec", 32'(oRecord), rec(0, 0, 37, 5, 90));
    tick();
    chk("t1_hs_valid", 32'(oRecValid), 0);
    chk("t1_rearm", 32'(oFineClr), 1);

    // 2: rise and fall together
    iRise = 1'b1;
    iFall = 1'b1;
    iCoarse = 10'd100;
    iDecStart = 7'd3;
    iDecStop = 7'd4;
    tick();
    iRise = 1'b0;
    iFall = 1'b0;
    tick();
    chk("t2_lat2", 32'(oRecValid), 0);
    tick();
    chk("t2_lat3", 32'(oRecValid), 1);
    chk("t2_rec", 32'(oRecord), rec(0, 1, 100, 3, 4));
    tick();

    // 3: timeout
    iRise = 1'b1;
    tick();
    iRise = 1'b0;
    iCoarse = 10'd1023;
    iDecStart = 7'd127;
    iDecStop = 7'd0;
    ticks(999);
    chk("t3_cen_last", 32'(oCoarseEn), 1);
    tick();
    chk("t3_cen_off", 32'(oCoarseEn), 0);
    chk("t3_not_yet", 32'(oRecValid), 0);
    ticks(2);
    chk("t3_valid", 32'(oRecValid), 1);
    chk("t3_rec", 32'(oRecord), rec(1, 0, 1023, 127, 0));
    tick();

    // 4: back-pressure with dropped hits
    iRecReady = 1'b0;
    hit(10, 200, 10, 20);
    wait_valid("t4_valid", 10);
    exp = rec(0, 0, 200, 10, 20);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      iRise = (i == 5 || i == 20 || i == 35);
      iCoarse = 10'(i);
      tick();
      if (oRecord !== 26'(exp) || !oRecValid) bad = 1'b1;
    end
    iRise = 1'b0;
    chk("t4_stable", 32'(bad), 0);
    chk("t4_drop", 32'(oDropCnt), 3);
    hbase = hs_cnt;
    iRecReady = 1'b1;
    tick();
    chk("t4_hs_clear", 32'(oRecValid), 0);
    chk("t4_rearm", 32'(oFineClr), 1);
    ticks(5);
    chk("t4_one_hs", 32'(hs_cnt - hbase), 1);

    // 5: reset while running
    iRise = 1'b1;
    tick();
    iRise = 1'b0;
    ticks(3);
    chk("t5_cen_pre", 32'(oCoarseEn), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", 32'(oRecValid), 0);
    chk("t5_cen", 32'(oCoarseEn), 0);
    chk("t5_busy", 32'(oBusy), 0);
    chk("t5_drop", 32'(oDropCnt), 0);

    // 6: four back-to-back hits
    tick();
    chk("t6_arm", 32'(oFineClr), 1);
    base = clr_cnt + 1;
    for (int k = 0; k < 4; k++) begin
      hit(4 + k, 10 * k + 1, k, k + 1);
      wait_valid("t6_valid", 10);
      chk("t6_rec", 32'(oRecord), rec(0, 0, 10 * k + 1, k, k + 1));
      tick();
    end
    tick();
    chk("t6_clr4", 32'(clr_cnt - base), 4);
    chk("t6_drop", 32'(oDropCnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
